xadc_drp_scheduler: RTL and testbench

// Owns the XADC DRP port and shares it between two requesters: the XADC itself, whose end-of-conversion

---
 rtl/xadc_drp_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_xadc_drp_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_scheduler.sv
// ---- xadc_drp_scheduler : shares the XADC DRP port between EOC result reads and a host port -- rev 1.0 ----
`default_nettype none

module xadc_drp_scheduler #(
  parameter int          NUM_CH      = 4,
  parameter logic [4:0]  CH_BASE     = 5'h15,
  parameter int          DRP_TIMEOUT = 64,
  localparam int         SLOT_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   eoc_in,
  input  logic [4:0]             channel_in,
  input  logic                   drdy_in,
  input  logic [15:0]            do_in,
  output logic                   den_out,
  output logic                   dwe_out,
  output logic [6:0]             daddr_out,
  output logic [15:0]            di_out,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [6:0]             host_addr,
  input  logic [15:0]            host_wdata,
  output logic                   host_ack,
  output logic [15:0]            host_rdata,
  output logic [12*NUM_CH-1:0]   sample_data,
  output logic [NUM_CH-1:0]      sample_valid,
  output logic                   sample_stb,
  output logic [SLOT_W-1:0]      sample_slot,
  output logic [7:0]             overrun_cnt,
  output logic                   timeout_err
);

  localparam int         CNT_W = $clog2(DRP_TIMEOUT + 1);
  localparam logic [5:0] CH_LO = {1'b0, CH_BASE};
  localparam logic [5:0] CH_HI = CH_LO + 6'(NUM_CH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EOC_ISSUE  = 3'd1,
    EOC_WAIT   = 3'd2,
    HOST_ISSUE = 3'd3,
    HOST_WAIT  = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic               pending;
  logic [4:0]         lat_ch;
  logic [SLOT_W-1:0]  lat_slot;
  logic [SLOT_W-1:0]  act_slot;
  logic [CNT_W-1:0]   wait_cnt;
  logic [6:0]         addr_q;
  logic [15:0]        di_q;
  logic               we_q;

  logic [5:0]         ch_ext;
  logic [5:0]         ch_off;
  logic               in_range;
  logic               eoc_take;
  logic               eoc_drop;
  logic               host_go;
  logic               wait_timeout;

  assign ch_ext       = {1'b0, channel_in};
  assign ch_off       = ch_ext - CH_LO;
  assign in_range     = (ch_ext >= CH_LO) && (ch_ext < CH_HI);
  assign eoc_take     = eoc_in && in_range && !pending;
  assign eoc_drop     = eoc_in && in_range && pending;
  // The ack cycle still sees host_req high; don't start a second access on it.
  assign host_go      = host_req && !host_ack;
  assign wait_timeout = (wait_cnt == CNT_W'(DRP_TIMEOUT));

  always_comb begin
    state_nx  = state;
    den_out   = 1'b0;
    dwe_out   = we_q;
    daddr_out = addr_q;
    di_out    = di_q;
    case (state)
      IDLE: begin
        if (pending)       state_nx = EOC_ISSUE;
        else if (host_go)  state_nx = HOST_ISSUE;
        else if (eoc_take) state_nx = EOC_ISSUE;
      end
      EOC_ISSUE: begin
        den_out   = 1'b1;
        dwe_out   = 1'b0;
        daddr_out = {2'b00, lat_ch};
        state_nx  = EOC_WAIT;
      end
      EOC_WAIT: begin
        if (drdy_in || wait_timeout) state_nx = IDLE;
      end
      HOST_ISSUE: begin
        den_out   = 1'b1;
        dwe_out   = host_we;
        daddr_out = host_addr;
        di_out    = host_wdata;
        state_nx  = HOST_WAIT;
      end
      HOST_WAIT: begin
        if (drdy_in || wait_timeout) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pending      <= 1'b0;
      lat_ch       <= '0;
      lat_slot     <= '0;
      act_slot     <= '0;
      wait_cnt     <= '0;
      addr_q       <= '0;
      di_q         <= '0;
      we_q         <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      sample_data  <= '0;
      sample_valid <= '0;
      sample_stb   <= 1'b0;
      sample_slot  <= '0;
      overrun_cnt  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      addr_q     <= daddr_out;
      di_q       <= di_out;
      we_q       <= dwe_out;
      sample_stb <= 1'b0;
      host_ack   <= 1'b0;

      if (state == EOC_ISSUE) begin
        pending  <= 1'b0;
        act_slot <= lat_slot;
      end
      // eoc_take implies pending=0, so it never collides with the clear above.
      if (eoc_take) begin
        pending  <= 1'b1;
        lat_ch   <= channel_in;
        lat_slot <= ch_off[SLOT_W-1:0];
      end
      if (eoc_drop && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;

      if (den_out)                                          wait_cnt <= CNT_W'(1);
      else if ((state == EOC_WAIT) || (state == HOST_WAIT)) wait_cnt <= wait_cnt + CNT_W'(1);

      if (state == EOC_WAIT) begin
        if (drdy_in) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (act_slot == SLOT_W'(k)) begin
              sample_data[12*k +: 12] <= do_in[15:4];
              sample_valid[k]         <= 1'b1;
            end
          end
          sample_stb  <= 1'b1;
          sample_slot <= act_slot;
        end else if (wait_timeout) begin
          timeout_err <= 1'b1;
        end
      end

      if (state == HOST_WAIT) begin
        if (drdy_in) begin
          if (!we_q) host_rdata <= do_in;
          host_ack <= 1'b1;
        end else if (wait_timeout) begin
          host_rdata  <= 16'hDEAD;
          host_ack    <= 1'b1;
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xadc_drp_scheduler.sv
// ---- tb_xadc_drp_scheduler : randomized scoreboard bench for xadc_drp_scheduler -- rev 1.0 ----
`default_nettype none

module tb_xadc_drp_scheduler;

  localparam int DRP_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        eoc_in;
  logic [4:0]  channel_in;
  logic        drdy_in;
  logic [15:0] do_in;
  logic        den_out, dwe_out;
  logic [6:0]  daddr_out;
  logic [15:0] di_out;
  logic        host_req, host_we;
  logic [6:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [47:0] sample_data;
  logic [3:0]  sample_valid;
  logic        sample_stb;
  logic [1:0]  sample_slot;
  logic [7:0]  overrun_cnt;
  logic        timeout_err;

  always #5 clk = ~clk;

  xadc_drp_scheduler dut (
    .clk(clk), .reset_n(reset_n), .eoc_in(eoc_in), .channel_in(channel_in),
    .drdy_in(drdy_in), .do_in(do_in), .den_out(den_out), .dwe_out(dwe_out),
    .daddr_out(daddr_out), .di_out(di_out), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_stb(sample_stb), .sample_slot(sample_slot), .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err)
  );

  typedef struct {
    bit          host;
    logic [6:0]  addr;
    bit          we;
    logic [15:0] di;
    int          slot;
    int          delay;   // 0 = never answer
    logic [15:0] data;
  } acc_t;

  typedef struct {
    int          slot;
    logic [11:0] val;
  } smp_t;

  acc_t        exp_drp[$];
  smp_t        exp_smp[$];
  logic [15:0] exp_host[$];

  int          checks = 0;
  int          failures = 0;
  bit          busy = 0;
  bit          flood = 0;
  logic [6:0]  flood_addr = '0;
  logic [15:0] model_rdata = '0;
  logic [47:0] model_data = '0;
  logic [3:0]  model_valid = '0;
  int          exp_ovr = 0;
  bit          exp_terr = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_eoc(input logic [4:0] ch, input int delay, input logic [15:0] data);
    acc_t e;
    e.host = 0; e.addr = {2'b00, ch}; e.we = 0; e.di = '0;
    e.slot = int'(ch) - 'h15; e.delay = delay; e.data = data;
    exp_drp.push_back(e);
  endtask

  task automatic push_host(input bit we, input logic [6:0] a, input logic [15:0] d,
                           input int delay, input logic [15:0] data);
    acc_t e;
    e.host = 1; e.addr = a; e.we = we; e.di = d;
    e.slot = 0; e.delay = delay; e.data = data;
    exp_drp.push_back(e);
  endtask

  // Called at a negedge; eoc_in is high for exactly one cycle.
  task automatic eoc_pulse(input logic [4:0] ch, input bit check_latency);
    eoc_in = 1'b1;
    channel_in = ch;
    @(negedge clk);
    eoc_in = 1'b0;
    channel_in = 5'($urandom);
    if (check_latency) chk(den_out == 1'b1, "den_latency", den_out, 1);
  endtask

  task automatic host_drive(input bit we, input logic [6:0] a, input logic [15:0] d);
    int n = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (!host_ack && n < 200);
    chk(host_ack == 1'b1, "host_ack_arrives", host_ack, 1);
    host_req = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_drp.size() != 0 || busy || exp_smp.size() != 0 || exp_host.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(n < 400, "quiet_timeout", n, 400);
    repeat (3) @(negedge clk);
  endtask

  // DRP responder: checks each issued access against the expected order and answers it.
  initial begin
    acc_t e;
    drdy_in = 1'b0;
    do_in = '0;
    forever begin
      @(negedge clk);
      if (den_out && reset_n) begin
        if (flood) begin
          chk(daddr_out == flood_addr && dwe_out == 1'b0, "flood_addr", daddr_out, flood_addr);
        end else if (exp_drp.size() == 0) begin
          chk(1'b0, "den_unexpected", daddr_out, 0);
        end else begin
          e = exp_drp.pop_front();
          busy = 1;
          chk(daddr_out == e.addr, "daddr", daddr_out, e.addr);
          chk(dwe_out == e.we, "dwe", dwe_out, e.we);
          if (e.host && e.we) chk(di_out == e.di, "di", di_out, e.di);
          if (e.delay == 0) begin
            if (e.host) begin
              model_rdata = 16'hDEAD;
              exp_host.push_back(model_rdata);
            end
            for (int i = 0; i < DRP_TIMEOUT + 1; i++) begin
              @(negedge clk);
              if (den_out) chk(1'b0, "den_overlap", daddr_out, 0);
            end
          end else begin
            for (int i = 1; i < e.delay; i++) begin
              @(negedge clk);
              if (den_out) chk(1'b0, "den_overlap", daddr_out, 0);
            end
            @(negedge clk);
            drdy_in = 1'b1;
            do_in = e.data;
            if (e.host) begin
              if (!e.we) model_rdata = e.data;
              exp_host.push_back(model_rdata);
            end else begin
              exp_smp.push_back('{e.slot, e.data[15:4]});
            end
            @(negedge clk);
            drdy_in = 1'b0;
            do_in = 16'($urandom);
            if (e.host) chk(host_ack == 1'b1, "ack_latency", host_ack, 1);
            else        chk(sample_stb == 1'b1, "stb_latency", sample_stb, 1);
          end
          busy = 0;
        end
      end
    end
  end

  // Sample monitor
  initial begin
    smp_t s;
    forever begin
      @(negedge clk);
      if (reset_n && sample_stb) begin
        if (exp_smp.size() == 0) begin
          chk(1'b0, "stb_unexpected", sample_slot, 0);
        end else begin
          s = exp_smp.pop_front();
          model_data[12*s.slot +: 12] = s.val;
          model_valid[s.slot] = 1'b1;
          chk(int'(sample_slot) == s.slot, "sample_slot", sample_slot, s.slot);
          chk(sample_data == model_data, "sample_data", sample_data, model_data);
          chk(sample_valid == model_valid, "sample_valid", sample_valid, model_valid);
        end
      end
    end
  end

  // Host monitor
  initial begin
    logic [15:0] r;
    forever begin
      @(negedge clk);
      if (reset_n && host_ack) begin
        if (exp_host.size() == 0) begin
          chk(1'b0, "ack_unexpected", host_rdata, 0);
        end else begin
          r = exp_host.pop_front();
          chk(host_rdata == r, "host_rdata", host_rdata, r);
        end
      end
    end
  end

  initial begin
    logic [4:0]  ch;
    logic [6:0]  a;
    logic [15:0] d;
    int          op, dly;

    reset_n = 1'b0;
    eoc_in = 1'b0; channel_in = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    chk(den_out == 0 && dwe_out == 0 && daddr_out == 0 && di_out == 0, "reset_drp",
        {dwe_out, daddr_out, di_out}, 0);
    chk(host_ack == 0 && host_rdata == 0, "reset_host", host_rdata, 0);
    chk(sample_data == 0 && sample_valid == 0 && sample_stb == 0, "reset_samples", sample_data, 0);
    chk(overrun_cnt == 0 && timeout_err == 0, "reset_status", {overrun_cnt, timeout_err}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single EOC read on VAUX5
    push_eoc(5'h15, 3, 16'hABC0);
    eoc_pulse(5'h15, 1);
    wait_quiet();
    chk(sample_data[11:0] == 12'hABC, "slot0_value", sample_data[11:0], 12'hABC);
    chk(sample_valid == 4'b0001, "valid_after_first", sample_valid, 4'b0001);

    // EOC during EOC_WAIT is buffered; a third one is dropped
    push_eoc(5'h15, 8, 16'($urandom));
    push_eoc(5'h16, 3, 16'($urandom));
    eoc_pulse(5'h15, 1);
    repeat (2) @(negedge clk);
    eoc_pulse(5'h16, 0);
    @(negedge clk);
    eoc_pulse(5'h17, 0);
    exp_ovr++;
    wait_quiet();
    chk(overrun_cnt == 8'(exp_ovr), "overrun_one", overrun_cnt, exp_ovr);

    // Same-cycle host_req and EOC: host is granted first
    push_host(1'b0, 7'h41, '0, 4, 16'h5A5A);
    push_eoc(5'h17, 2, 16'($urandom));
    fork
      host_drive(1'b0, 7'h41, '0);
      eoc_pulse(5'h17, 0);
    join
    wait_quiet();

    // Pending EOC wins over a host request raised right after an ack
    push_host(1'b0, 7'h41, '0, 6, 16'($urandom));
    push_eoc(5'h18, 2, 16'($urandom));
    push_host(1'b0, 7'h42, '0, 2, 16'($urandom));
    fork
      begin
        host_drive(1'b0, 7'h41, '0);
        host_drive(1'b0, 7'h42, '0);
      end
      begin
        repeat (3) @(negedge clk);
        eoc_pulse(5'h18, 0);
      end
    join
    wait_quiet();

    // Host write leaves host_rdata unchanged
    push_host(1'b1, 7'h40, 16'h1234, 2, 16'($urandom));
    host_drive(1'b1, 7'h40, 16'h1234);
    wait_quiet();

    // Unanswered host read times out, then the port keeps working
    push_host(1'b0, 7'h41, '0, 0, '0);
    exp_terr = 1;
    host_drive(1'b0, 7'h41, '0);
    wait_quiet();
    chk(timeout_err == 1'b1, "timeout_sticky", timeout_err, 1);
    push_host(1'b0, 7'h43, '0, 5, 16'($urandom));
    host_drive(1'b0, 7'h43, '0);
    wait_quiet();

    // Out-of-range channels: no access, no count
    eoc_pulse(5'h03, 0);
    eoc_pulse(5'h14, 0);
    eoc_pulse(5'h19, 0);
    repeat (10) @(negedge clk);
    chk(overrun_cnt == 8'(exp_ovr), "out_of_range_ignored", overrun_cnt, exp_ovr);

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      op  = int'($urandom_range(0, 2));
      dly = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      if (dly == 0) exp_terr = 1;
      if (op == 0) begin
        ch = 5'h15 + 5'($urandom_range(0, 3));
        push_eoc(ch, dly, 16'($urandom));
        eoc_pulse(ch, 1);
      end else begin
        a = 7'($urandom);
        d = 16'($urandom);
        push_host(op == 2, a, d, dly, 16'($urandom));
        host_drive(op == 2, a, d);
      end
      wait_quiet();
      chk(timeout_err == exp_terr, "timeout_err_state", timeout_err, exp_terr);
      chk(overrun_cnt == 8'(exp_ovr), "overrun_state", overrun_cnt, exp_ovr);
    end

    // Flood of EOCs against an unresponsive DRP: overrun saturates
    flood_addr = 7'h17;
    flood = 1;
    exp_terr = 1;
    for (int i = 0; i < 320; i++) begin
      eoc_in = 1'b1;
      channel_in = 5'h17;
      @(negedge clk);
    end
    eoc_in = 1'b0;
    repeat (3 * DRP_TIMEOUT) @(negedge clk);
    flood = 0;
    chk(overrun_cnt == 8'hFF, "overrun_saturate", overrun_cnt, 8'hFF);
    chk(timeout_err == 1'b1, "timeout_after_flood", timeout_err, 1);
    chk(sample_valid == model_valid, "valid_after_flood", sample_valid, model_valid);
    eoc_pulse(5'h03, 0);
    repeat (10) @(negedge clk);
    chk(overrun_cnt == 8'hFF, "overrun_hold", overrun_cnt, 8'hFF);

    chk(exp_drp.size() == 0 && exp_smp.size() == 0 && exp_host.size() == 0, "queues_drained",
        exp_drp.size() + exp_smp.size() + exp_host.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
